qoa_slice_dequant: RTL and testbench
====================================

# qoa_slice_dequant

Streaming QOA slice dequantizer. Accepts one packed 64-bit QOA slice (4-bit scale factor plus 20 three-bit quantized residuals) per handshake. Emits the 20 dequantized signed residuals one per beat on a valid/ready stream, tagged with channel and sample index. Sits between the frame/slice parser and the LMS predictor. Generalises the fixed 16×8 dequant lookup with parametrised output width, channel tagging and sequential slice unpacking with back-pressure.

## Interface
Parameters:
- OUT_W, 16, output sample width; legal range ≥ 15; values are sign-extended to this width.
- CH_W, 1, channel tag width; supports up to 2^CH_W interleaved channels.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- slice_valid  in  1  slice word present.
- slice_ready  out  1  block accepts slice this cycle.
- slice_data  in  64  packed slice: [63:60] sf, [59:57] r0, [56:54] r1 … [2:0] r19.
- slice_ch  in  CH_W  channel tag for the slice.
- out_valid  out  1  dequantized sample present.
- out_ready  in  1  downstream accepts sample.
- out_data  out  OUT_W  signed dequantized residual.
- out_ch  out  CH_W  channel tag of the current slice.
- out_idx  out  5  sample index within slice, 0..19.
- out_last  out  1  high when out_idx == 19.

## Operation
- Dequant value: deq(sf, qr) = (qr[0] ? −M : +M), where M = MAG[sf][qr[2:1]].
- MAG row sf=0: 1, 3, 5, 7; row sf=15: 1536, 5120, 9216, 14336. The full 16×4 magnitude table lives in the package.
- The result is a 15-bit signed value, sign-extended to OUT_W.
- FSM has two states, IDLE and RUN.
- IDLE:
  - slice_ready = 1 and out_valid = 0.
  - On slice handshake: latch sf and slice_ch.
  - Load out_data ← deq(sf, r0), out_idx ← 0, out_valid ← 1.
  - Load the 57-bit residual shift register with r1..r19 (MSB-first).
  - Go to RUN.
- RUN:
  - out_valid = 1.
  - On out handshake with out_idx < 19: out_data ← deq(sf, shift head), shift left 3, out_idx++.
  - On out handshake with out_idx == 19: the slice is complete.
    - If slice_valid is also high, accept the new slice in the same cycle (load as in IDLE, stay in RUN).
    - Otherwise clear out_valid and go to IDLE.
- slice_ready = IDLE | (RUN & out_last & out_ready). This is a combinational path from out_ready, which is permitted.
- Output stream rules:
  - out_data, out_ch, out_idx and out_last are held stable while out_valid & !out_ready.
  - out_valid is never dropped without a handshake.
- slice_data and slice_ch are sampled only on a slice handshake. They are don't-care otherwise.

## Timing
- Reset values: out_valid 0, out_data 0, out_ch 0, out_idx 0, out_last 0, FSM IDLE (so slice_ready 1), shift register 0.
- Latency: the first sample is valid on the cycle after slice acceptance. All outputs are registered except slice_ready.
- Throughput: 1 sample/cycle with out_ready held high. A slice takes 20 cycles. Back-to-back slices have zero bubbles.
- Back-pressure: any out_ready pattern; the sample order r0..r19 is preserved exactly.
- Reset mid-slice: the in-flight slice is discarded, outputs return to reset values immediately (asynchronous), and no partial slice resumes.
- A slice_valid held high in RUN before the last beat is not accepted (slice_ready = 0).

## Structure
- Package qoa_pkg holds:
  - SLICE_W = 64, N_RES = 20, SF_W = 4, QR_W = 3, DEQ_W = 15.
  - The 16×4 MAG magnitude constant array.
- Sub-module qoa_dequant_table: combinational (sf, qr) → signed DEQ_W, implementing deq() from the package table.
  - Instantiated once.
  - Its input mux selects slice_data[59:57] on a load and the shift-register head otherwise.
- The top level holds the FSM, shift register, index counter and output registers.

## Test plan
- Single slice, sf=0, residual codes 0..7 then 0..7 then 0..3, out_ready=1:
  - Required output: 1, −1, 3, −3, 5, −5, 7, −7, repeated, ending 1, −1, 3, −3.
  - out_idx runs 0..19, out_last only on idx 19, and out_valid is low the cycle after.
- sf=15, all codes 7, OUT_W=16: every out_data = −14336 (0xC800). With OUT_W=20: 0xFC800.
- Back-to-back: two slices with slice_valid held high, ch tags 0 then 1, out_ready=1:
  - 40 consecutive valid beats with no gap.
  - out_ch switches 0→1 exactly at the beat after idx 19.
- Random out_ready (50%) over sf=9 with codes 2,3: the stream is exactly 1405, −1405, … in order, and the outputs are stable during stalls.
- Assert rst at out_idx=7 mid-stall:
  - out_valid=0, out_idx=0 and slice_ready=1 immediately.
  - A fresh slice after release starts at idx 0 with the new values.

Source files
------------

// File: rtl/qoa_pkg.sv
// Shared constants, FSM state type and the QOA dequantisation magnitude table.
package qoa_pkg;

  localparam int SLICE_W = 64;
  localparam int N_RES   = 20;
  localparam int SF_W    = 4;
  localparam int QR_W    = 3;
  localparam int DEQ_W   = 15;
  localparam int IDX_W   = 5;
  // Residuals r1..r19 held after r0 has been consumed at load time.
  localparam int SHIFT_W = (N_RES - 1) * QR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Magnitude per scale factor (row) and code magnitude qr[2:1] (column).
  // Row s is round(scalefactor(s) * {0.75, 2.5, 4.5, 7.0}).
  localparam logic [DEQ_W-2:0] MAG [16][4] = '{
    '{14'd1,    14'd3,    14'd5,    14'd7    },
    '{14'd5,    14'd18,   14'd32,   14'd49   },
    '{14'd16,   14'd53,   14'd95,   14'd147  },
    '{14'd34,   14'd113,  14'd203,  14'd315  },
    '{14'd63,   14'd210,  14'd378,  14'd588  },
    '{14'd104,  14'd345,  14'd621,  14'd966  },
    '{14'd158,  14'd528,  14'd950,  14'd1477 },
    '{14'd228,  14'd760,  14'd1368, 14'd2128 },
    '{14'd316,  14'd1053, 14'd1895, 14'd2947 },
    '{14'd422,  14'd1405, 14'd2529, 14'd3934 },
    '{14'd548,  14'd1828, 14'd3290, 14'd5117 },
    '{14'd696,  14'd2320, 14'd4176, 14'd6496 },
    '{14'd868,  14'd2893, 14'd5207, 14'd8099 },
    '{14'd1064, 14'd3548, 14'd6386, 14'd9933 },
    '{14'd1286, 14'd4288, 14'd7718, 14'd12005},
    '{14'd1536, 14'd5120, 14'd9216, 14'd14336}
  };

endpackage

// File: rtl/qoa_dequant_table.sv
// Combinational QOA dequantiser: (scale factor, 3-bit code) -> signed residual.
// Code bit 0 selects the sign, bits 2:1 select the magnitude column.
module qoa_dequant_table
  import qoa_pkg::*;
(
  input  logic [SF_W-1:0]         sf_i,
  input  logic [QR_W-1:0]         qr_i,
  output logic signed [DEQ_W-1:0] deq_o
);

  logic [DEQ_W-2:0]         mag;
  logic signed [DEQ_W-1:0]  mag_s;

  // Table lookup and sign application
  always_comb begin
    mag   = MAG[sf_i][qr_i[2:1]];
    mag_s = $signed({1'b0, mag});
    deq_o = qr_i[0] ? -mag_s : mag_s;
  end

endmodule

// File: rtl/qoa_slice_dequant.sv
// Streaming QOA slice dequantiser: takes one packed 64-bit slice per handshake
// and emits its 20 dequantised residuals, one per beat, tagged with channel
// and index. The final beat of a slice can overlap acceptance of the next one.
module qoa_slice_dequant
  import qoa_pkg::*;
#(
  parameter int OUT_W = 16,
  parameter int CH_W  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               slice_valid,
  output logic               slice_ready,
  input  logic [SLICE_W-1:0] slice_data,
  input  logic [CH_W-1:0]    slice_ch,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last
);

  state_e                  state_q, state_d;
  logic [SF_W-1:0]         sf_q, sf_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    last_q, last_d;
  logic                    valid_q, valid_d;
  logic signed [OUT_W-1:0] data_q, data_d;

  logic                    load;
  logic                    adv;
  logic                    done;
  logic [SF_W-1:0]         tbl_sf;
  logic [QR_W-1:0]         tbl_qr;
  logic signed [DEQ_W-1:0] tbl_deq;

  // Single shared lookup: r0 of an incoming slice on load, shift head otherwise.
  qoa_dequant_table u_table (
    .sf_i  (tbl_sf),
    .qr_i  (tbl_qr),
    .deq_o (tbl_deq)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave RUN only when the last beat drains with no follow-on slice
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (slice_valid) state_d = ST_RUN;
      ST_RUN:  if (out_ready && last_q && !slice_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: slice_ready looks through out_ready so back-to-back slices have no bubble
  always_comb begin
    slice_ready = (state_q == ST_IDLE) || ((state_q == ST_RUN) && last_q && out_ready);
    load        = slice_valid && slice_ready;
    adv         = (state_q == ST_RUN) && out_ready && !last_q;
    done        = (state_q == ST_RUN) && out_ready && last_q;
  end

  // Datapath next state: load a slice, advance one residual, or drop valid after the last beat
  always_comb begin
    sf_d    = sf_q;
    ch_d    = ch_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    tbl_sf  = load ? slice_data[SLICE_W-1 -: SF_W] : sf_q;
    tbl_qr  = load ? slice_data[SLICE_W-SF_W-1 -: QR_W] : shift_q[SHIFT_W-1 -: QR_W];
    if (load) begin
      sf_d    = slice_data[SLICE_W-1 -: SF_W];
      ch_d    = slice_ch;
      shift_d = slice_data[SHIFT_W-1:0];
      idx_d   = '0;
      last_d  = 1'b0;
      valid_d = 1'b1;
      data_d  = OUT_W'(tbl_deq);
    end else if (adv) begin
      shift_d = {shift_q[SHIFT_W-QR_W-1:0], {QR_W{1'b0}}};
      idx_d   = idx_q + IDX_W'(1);
      last_d  = (idx_q == IDX_W'(N_RES - 2));
      data_d  = OUT_W'(tbl_deq);
    end else if (done) begin
      valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sf_q    <= '0;
      ch_q    <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      sf_q    <= sf_d;
      ch_q    <= ch_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_qoa_slice_dequant.sv
// Bench for qoa_slice_dequant: a 16-bit and a 20-bit instance share stimulus;
// a scoreboard of expected beats is filled on slice acceptance and drained on
// output handshakes.
module tb_qoa_slice_dequant;

  localparam int CH_W = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            slice_valid;
  logic [63:0]     slice_data;
  logic [CH_W-1:0] slice_ch;
  logic            out_ready;

  logic            slice_ready, out_valid, out_last;
  logic [15:0]     out_data;
  logic [CH_W-1:0] out_ch;
  logic [4:0]      out_idx;

  logic            slice_ready_w, out_valid_w, out_last_w;
  logic [19:0]     out_data_w;
  logic [CH_W-1:0] out_ch_w;
  logic [4:0]      out_idx_w;

  always #5 clk = ~clk;

  qoa_slice_dequant #(.OUT_W(16), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst),
    .slice_valid(slice_valid), .slice_ready(slice_ready),
    .slice_data(slice_data), .slice_ch(slice_ch),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx), .out_last(out_last)
  );

  qoa_slice_dequant #(.OUT_W(20), .CH_W(CH_W)) dut_w (
    .clk(clk), .rst(rst),
    .slice_valid(slice_valid), .slice_ready(slice_ready_w),
    .slice_data(slice_data), .slice_ch(slice_ch),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_data(out_data_w), .out_ch(out_ch_w), .out_idx(out_idx_w), .out_last(out_last_w)
  );

  typedef struct {
    int val;
    int ch;
    int idx;
  } exp_t;

  typedef struct {
    logic [3:0] sf;
    logic [2:0] qr;
    int         exp;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_rdy = 1'b0;
  int   run_len = 0;
  int   max_run = 0;

  int   codes[20];
  int   exps[20];
  int   pend_vals[20];
  int   pend_ch;
  bit   accepted;

  bit          prev_stall = 1'b0;
  logic [15:0] s_data;
  logic [CH_W-1:0] s_ch;
  logic [4:0]  s_idx;
  logic        s_last;

  // Reference: round(scalefactor * {0.75,2.5,4.5,7}) computed in quarters.
  function automatic int model_deq(int sf, int q);
    int sft[16] = '{1, 7, 21, 45, 84, 138, 211, 304, 421, 562, 731, 928, 1157, 1419, 1715, 2048};
    int k4[4]   = '{3, 10, 18, 28};
    int mag;
    mag = (sft[sf] * k4[q / 2] + 2) / 4;
    return (q % 2 != 0) ? -mag : mag;
  endfunction

  function automatic logic [63:0] pack(int sf, int cd[20]);
    logic [63:0] d;
    d = '0;
    d[63:60] = 4'(sf);
    for (int i = 0; i < 20; i++) d[59 - 3*i -: 3] = 3'(cd[i]);
    return d;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic fill_model(input int sf);
    for (int i = 0; i < 20; i++) exps[i] = model_deq(sf, codes[i]);
  endtask

  // Per-cycle observation at the falling edge, then advance to just after the rising edge.
  task automatic tick();
    exp_t e;
    bit   ok;
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("slice_ready_rule", int'(slice_ready), int'(!out_valid || (out_last && out_ready)));
      if (prev_stall) begin
        n_tests++;
        if (!(out_valid && out_data == s_data && out_ch == s_ch && out_idx == s_idx && out_last == s_last)) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b d=%0d idx=%0d, held d=%0d idx=%0d",
                   out_valid, $signed(out_data), out_idx, $signed(s_data), s_idx);
        end
      end
      prev_stall = out_valid && !out_ready;
      s_data = out_data; s_ch = out_ch; s_idx = out_idx; s_last = out_last;
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", int'(out_idx), -1);
        end else begin
          e = sb.pop_front();
          n_tests++;
          ok = ($signed(out_data) == e.val) && ($signed(out_data_w) == e.val) &&
               (int'(out_ch) == e.ch) && (int'(out_idx) == e.idx) &&
               (out_last == (e.idx == 19)) && out_valid_w;
          if (!ok) begin
            n_fail++;
            $display("FAIL beat: got d16=%0d d20=%0d ch=%0d idx=%0d last=%0b, expected d=%0d ch=%0d idx=%0d",
                     $signed(out_data), $signed(out_data_w), out_ch, out_idx, out_last, e.val, e.ch, e.idx);
          end
        end
      end
      if (slice_valid && slice_ready && !accepted) begin
        for (int i = 0; i < 20; i++) begin
          e.val = pend_vals[i];
          e.ch  = pend_ch;
          e.idx = i;
          sb.push_back(e);
        end
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a slice built from codes[]/exps[] and wait (bounded) for its acceptance.
  task automatic offer(input int sf, input int ch);
    slice_data  = pack(sf, codes);
    slice_ch    = CH_W'(ch);
    slice_valid = 1'b1;
    pend_vals   = exps;
    pend_ch     = ch;
    accepted    = 1'b0;
    for (int c = 0; c < 200 && !accepted; c++) tick();
    check("slice_accept", int'(accepted), 1);
  endtask

  // Wait for the scoreboard to empty, then require out_valid low on the following cycle.
  task automatic drain_idle();
    for (int c = 0; c < 400 && sb.size() != 0; c++) tick();
    check("drain", sb.size(), 0);
    @(negedge clk);
    check("valid_after_last", int'(out_valid), 0);
    run_len    = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[11];

  initial begin
    vecs = '{
      '{4'd0,  3'd0, 1},     '{4'd0,  3'd7, -7},    '{4'd15, 3'd7, -14336},
      '{4'd15, 3'd0, 1536},  '{4'd9,  3'd2, 1405},  '{4'd9,  3'd3, -1405},
      '{4'd1,  3'd2, 18},    '{4'd12, 3'd5, -5207}, '{4'd14, 3'd6, 12005},
      '{4'd7,  3'd4, 1368},  '{4'd3,  3'd1, -34}
    };

    rst = 1'b1; slice_valid = 1'b0; slice_data = '0; slice_ch = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_data_w", int'(out_data_w), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_slice_ready", int'(slice_ready), 1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    // Codes 0..7, 0..7, 0..3 at sf=0
    for (int i = 0; i < 20; i++) codes[i] = i % 8;
    fill_model(0);
    offer(0, 0);
    slice_valid = 1'b0;
    drain_idle();

    // Constant-code slices against hand-written table points
    foreach (vecs[k]) begin
      for (int i = 0; i < 20; i++) begin
        codes[i] = int'(vecs[k].qr);
        exps[i]  = vecs[k].exp;
      end
      offer(int'(vecs[k].sf), k % 2);
      slice_valid = 1'b0;
      drain_idle();
    end

    // Back-to-back slices, channel 0 then 1, no bubble
    max_run = 0;
    run_len = 0;
    for (int i = 0; i < 20; i++) codes[i] = $urandom_range(0, 7);
    fill_model(6);
    offer(6, 0);
    for (int i = 0; i < 20; i++) codes[i] = $urandom_range(0, 7);
    fill_model(13);
    offer(13, 1);
    slice_valid = 1'b0;
    drain_idle();
    check("b2b_run_length", max_run, 40);

    // Random back-pressure over sf=9, codes 2,3
    rand_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 20; i++) codes[i] = (i % 2 == 0) ? 2 : 3;
      fill_model(9);
      offer(9, (s + 1) % 2);
      slice_valid = 1'b0;
      drain_idle();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    // Reset while stalled at index 7
    for (int i = 0; i < 20; i++) codes[i] = $urandom_range(0, 7);
    fill_model(5);
    offer(5, 1);
    slice_valid = 1'b0;
    for (int c = 0; c < 50 && !(out_valid && out_idx == 5'd7); c++) tick();
    check("reached_idx7", int'(out_idx), 7);
    out_ready = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_idx", int'(out_idx), 0);
    check("mid_rst_slice_ready", int'(slice_ready), 1);
    check("mid_rst_out_data", int'(out_data), 0);
    sb.delete();
    prev_stall = 1'b0;
    run_len = 0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) codes[i] = 7 - (i % 8);
    fill_model(11);
    offer(11, 0);
    slice_valid = 1'b0;
    drain_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
